seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_comb.sv | 71 +++++++
 rtl/seq_alu.sv | 141 ++++++++++++++
 tb/tb_seq_alu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status-flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_OR  = 3'b000,
    OP_XOR = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic cout;
    logic negative;
    logic zero;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath for the seven single-cycle opcodes; MUL yields zero here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] shr;
  logic           shamt_zero;
  logic           shamt_big;

  // Extra bit on each side captures carry/not-borrow or the last bit shifted out.
  assign sum        = {1'b0, a_i} + {1'b0, b_i};
  assign diff       = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH + 1)'(1);
  assign shl        = {1'b0, a_i} << b_i;
  assign shr        = {a_i, 1'b0} >> b_i;
  assign shamt_zero = (b_i == '0);
  assign shamt_big  = ({1'b0, b_i} >= WIDTH_V);

  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_AND: result_o = a_i & b_i;
      OP_ADD: begin
        result_o         = sum[WIDTH-1:0];
        flags_o.cout     = sum[WIDTH];
        flags_o.overflow = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        result_o         = diff[WIDTH-1:0];
        flags_o.cout     = diff[WIDTH];
        flags_o.overflow = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_SHL: begin
        if (shamt_zero) begin
          result_o = a_i;
        end else if (!shamt_big) begin
          result_o     = shl[WIDTH-1:0];
          flags_o.cout = shl[WIDTH];
        end
      end
      OP_SHR: begin
        if (shamt_zero) begin
          result_o = a_i;
        end else if (!shamt_big) begin
          result_o     = shr[WIDTH:1];
          flags_o.cout = shr[0];
        end
      end
      default: ;
    endcase
    flags_o.negative = result_o[MSB];
    flags_o.zero     = (result_o == '0);
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked, registered ALU: single-cycle logic/arith/shift ops plus a
// WIDTH-cycle shift-add unsigned multiply, with registered status flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             negative,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  flags_t             flags_q, flags_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  op_e                op_in;
  logic [WIDTH-1:0]   alu_result;
  flags_t             alu_flags;
  logic [2*WIDTH-1:0] acc_sum;

  assign op_in    = op_e'(sel);
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .a_i      (a),
    .b_i      (b),
    .op_i     (op_in),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE with out_ready behaves like IDLE for a fresh accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)                               state_d = (op_in == OP_MUL) ? EXEC : DONE;
        else if ((state_q == DONE) && out_ready)  state_d = IDLE;
      end
      EXEC:    if (cnt_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, one multiplier bit per EXEC cycle
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      if (op_in == OP_MUL) begin
        out_valid_d = 1'b0;
        mcand_d     = {{WIDTH{1'b0}}, a};
        mplier_d    = b;
        acc_d       = '0;
        cnt_d       = CNT_INIT;
      end else begin
        result_d    = alu_result;
        flags_d     = alu_flags;
        out_valid_d = 1'b1;
      end
    end else if (state_q == EXEC) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        cnt_d            = '0;
        result_d         = acc_sum[WIDTH-1:0];
        flags_d.cout     = |acc_sum[2*WIDTH-1:WIDTH];
        flags_d.overflow = |acc_sum[2*WIDTH-1:WIDTH];
        flags_d.negative = acc_sum[WIDTH-1];
        flags_d.zero     = (acc_sum[WIDTH-1:0] == '0);
        out_valid_d      = 1'b1;
      end
    end else if ((state_q == DONE) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign result    = result_q;
  assign cout      = flags_q.cout;
  assign negative  = flags_q.negative;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=4.
module tb_seq_alu;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         negative;
  logic         zero;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       c;
    logic       n;
    logic       z;
    logic       v;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vec[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] r, input logic c,
                         input logic n, input logic z, input logic v);
    chk({name, ".result"},   32'(result),   32'(r));
    chk({name, ".cout"},     32'(cout),     32'(c));
    chk({name, ".negative"}, 32'(negative), 32'(n));
    chk({name, ".zero"},     32'(zero),     32'(z));
    chk({name, ".overflow"}, 32'(overflow), 32'(v));
  endtask

  // Accept a MUL at the current negedge, scramble inputs during EXEC, check latency and result.
  task automatic run_mul(input string name, input logic [3:0] ma, input logic [3:0] mb,
                         input logic [3:0] r, input logic c, input logic n,
                         input logic z, input logic v);
    int lat;
    lat = 0;
    a = ma; b = mb; sel = 3'b111; in_valid = 1'b1;
    #1 chk({name, ".in_ready_at_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      chk({name, ".in_ready_exec"}, 32'(in_ready), 32'd0);
      a   = ~a;
      b   = b + 4'd3;
      sel = 3'(lat);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, ".latency"}, 32'(lat), 32'd4);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
    chk_out(name, r, c, n, z, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //            sel     a        b        res      c     n     z     v
    vec[0]  = '{3'b010, 4'b1110, 4'b0101, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[2]  = '{3'b011, 4'b0100, 4'b0111, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{3'b011, 4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{3'b101, 4'b1011, 4'b0001, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{3'b110, 4'b1011, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{3'b000, 4'b1010, 4'b0101, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{3'b001, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{3'b100, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{3'b101, 4'b1011, 4'b0000, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[10] = '{3'b110, 4'b1011, 4'b0001, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[11] = '{3'b110, 4'b1011, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[12] = '{3'b011, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[13] = '{3'b010, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[14] = '{3'b101, 4'b0001, 4'b0011, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[15] = '{3'b101, 4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[16] = '{3'b110, 4'b1000, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sel = 3'b000;
    #12;
    chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.out_valid", 32'(out_valid), 32'd0);

    // Back-to-back single-cycle ops, one accept per edge
    for (int i = 0; i < NVEC; i++) begin
      a = vec[i].a; b = vec[i].b; sel = vec[i].sel;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk_out($sformatf("vec%0d", i), vec[i].res, vec[i].c, vec[i].n, vec[i].z, vec[i].v);
    end

    // Drain to IDLE: out_valid drops, result and flags are retained
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk_out("drain", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

    out_ready = 1'b0;
    run_mul("mul_6x3", 4'b0110, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: everything holds while out_ready is low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
      chk_out($sformatf("hold%0d", i), 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Release and accept a new op on the same edge
    out_ready = 1'b1; in_valid = 1'b1;
    a = 4'b1010; b = 4'b0101; sel = 3'b000;
    #1 chk("release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("release.out_valid", 32'(out_valid), 32'd1);
    chk_out("release_or", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

    // MUL accepted straight from DONE, then another from DONE
    run_mul("mul_15x15", 4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    run_mul("mul_3x5", 4'b0011, 4'b0101, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset asserted away from any clock edge during the second EXEC cycle
    a = 4'b0110; b = 4'b0011; sel = 3'b111; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 32'(out_valid), 32'd0);
    chk("midreset.in_ready", 32'(in_ready), 32'd1);
    chk_out("midreset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_reset%0d.out_valid", i), 32'(out_valid), 32'd0);
    end

    a = 4'b0011; b = 4'b0100; sel = 3'b010; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_reset_add.out_valid", 32'(out_valid), 32'd1);
    chk_out("post_reset_add", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
